// File: rtl/board_io_pkg.sv
// Shared encodings and widths for the board-input conditioner.
// The optional AUTO_REPEAT_EN build macro is consumed by board_input_conditioner.
package board_io_pkg;

  localparam int unsigned LED_W = 2;
  localparam int unsigned SSD_W = 4;
  localparam int unsigned SW_W  = LED_W + SSD_W;
  localparam int unsigned CNT_W = 16;

  localparam logic [15:0] DEBOUNCE_CYCLES_DEF = 16'd50000;

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE         = S_IDLE,
    ST_PRESS_WAIT   = S_PRESS_WAIT,
    ST_PRESSED      = S_PRESSED,
    ST_RELEASE_WAIT = S_RELEASE_WAIT
  } state_t;

endpackage

// File: rtl/board_input_conditioner_if.sv
// Raw board inputs and their conditioned counterparts.
// master = board/stimulus side, slave = conditioner.
interface board_io_if;
  import board_io_pkg::*;

  logic              stepBtnRaw;
  logic [LED_W-1:0]  ledSelRaw;
  logic [SSD_W-1:0]  ssdSelRaw;
  logic [LED_W-1:0]  ledSel;
  logic [SSD_W-1:0]  ssdSel;
  logic              stepPulse;
  logic              btnState;
  logic [CNT_W-1:0]  stepCount;

  modport master (
    output stepBtnRaw, ledSelRaw, ssdSelRaw,
    input  ledSel, ssdSel, stepPulse, btnState, stepCount
  );

  modport slave (
    input  stepBtnRaw, ledSelRaw, ssdSelRaw,
    output ledSel, ssdSel, stepPulse, btnState, stepCount
  );

endinterface

// File: rtl/board_input_conditioner_sync_2ff.sv
// Two-flop synchroniser bank; output is the second stage.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/board_input_conditioner.sv
// Switch synchronisation plus step-button debounce/pulse generation.
// Define AUTO_REPEAT_EN to enable hold-to-repeat step pulses.
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [23:0] HOLD_CYCLES     = 24'd5000000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd1000000
) (
  input  logic       BoardClk,
  input  logic       rst,
  board_io_if.slave  io
);

  logic [SW_W-1:0]  w_sw_sync;
  logic             w_btn_sync;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_cnt;
  logic [15:0]      w_cnt_nxt;
  logic             w_accept;
  logic             w_rep_fire;

  logic             r_fire;
  logic             r_step_pulse;
  logic             r_btn_state;
  logic [CNT_W-1:0] r_step_count;

  sync_2ff #(.WIDTH(SW_W)) u_sw_sync (
    .clk (BoardClk),
    .rst (rst),
    .i_d ({io.ledSelRaw, io.ssdSelRaw}),
    .o_q (w_sw_sync)
  );

  sync_2ff #(.WIDTH(1)) u_btn_sync (
    .clk (BoardClk),
    .rst (rst),
    .i_d (io.stepBtnRaw),
    .o_q (w_btn_sync)
  );

  always_ff @(posedge BoardClk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Any change of the synced level restarts the stability count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_btn_sync) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = 16'd1;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_btn_sync) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt == DEBOUNCE_CYCLES - 16'd1) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = 16'd0;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      ST_PRESSED: begin
        if (!w_btn_sync) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = 16'd1;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_btn_sync) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt == DEBOUNCE_CYCLES - 16'd1) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  logic [23:0] r_hold_cnt;
  logic [23:0] r_rep_cnt;
  logic        r_repeating;
  logic        w_held;

  assign w_held     = (r_state == ST_PRESSED) && w_btn_sync;
  assign w_rep_fire = w_held && (r_repeating ? (r_rep_cnt == REPEAT_CYCLES - 24'd1)
                                             : (r_hold_cnt == HOLD_CYCLES - 24'd1));

  // Hold phase runs once per PRESSED visit, then the repeat period free-runs.
  always_ff @(posedge BoardClk or posedge rst) begin
    if (rst) begin
      r_hold_cnt  <= 24'd0;
      r_rep_cnt   <= 24'd0;
      r_repeating <= 1'b0;
    end else if (!w_held) begin
      r_hold_cnt  <= 24'd0;
      r_rep_cnt   <= 24'd0;
      r_repeating <= 1'b0;
    end else if (!r_repeating) begin
      if (r_hold_cnt == HOLD_CYCLES - 24'd1) r_repeating <= 1'b1;
      else                                  r_hold_cnt  <= r_hold_cnt + 24'd1;
    end else begin
      if (r_rep_cnt == REPEAT_CYCLES - 24'd1) r_rep_cnt <= 24'd0;
      else                                    r_rep_cnt <= r_rep_cnt + 24'd1;
    end
  end
`else
  logic w_unused_params;
  assign w_unused_params = ^{HOLD_CYCLES, REPEAT_CYCLES};
  assign w_rep_fire      = 1'b0;
`endif

  // Pulse and debounced level trail the FSM state by one cycle.
  always_ff @(posedge BoardClk or posedge rst) begin
    if (rst) begin
      r_fire       <= 1'b0;
      r_step_pulse <= 1'b0;
      r_btn_state  <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_fire       <= w_accept | w_rep_fire;
      r_step_pulse <= r_fire;
      r_btn_state  <= (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);
      if (r_fire) r_step_count <= r_step_count + CNT_W'(1);
    end
  end

  assign io.ledSel    = w_sw_sync[SSD_W +: LED_W];
  assign io.ssdSel    = w_sw_sync[SSD_W-1:0];
  assign io.stepPulse = r_step_pulse;
  assign io.btnState  = r_btn_state;
  assign io.stepCount = r_step_count;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner; also covers AUTO_REPEAT_EN when defined.
module tb_board_input_conditioner;
  import board_io_pkg::*;

`ifdef AUTO_REPEAT_EN
  localparam int CLEAN_PULSES = 4;
`else
  localparam int CLEAN_PULSES = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   q_pulse[$];
  int   t0;
  int   off;

  board_io_if io ();

  board_input_conditioner #(
    .DEBOUNCE_CYCLES (16'd4),
    .HOLD_CYCLES     (24'd10),
    .REPEAT_CYCLES   (24'd3)
  ) dut (
    .BoardClk (clk),
    .rst      (rst),
    .io       (io)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) if (io.stepPulse === 1'b1) q_pulse.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_off(input int base);
    return (q_pulse.size() > 0) ? q_pulse[0] - base : -1;
  endfunction

  initial begin
    io.stepBtnRaw = 1'b0;
    io.ledSelRaw  = '0;
    io.ssdSelRaw  = '0;

    // Reset with inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      io.stepBtnRaw = 1'($urandom_range(1));
      io.ledSelRaw  = 2'($urandom);
      io.ssdSelRaw  = 4'($urandom);
    end
    @(negedge clk);
    check("rst_ledSel",    32'(io.ledSel),    32'd0);
    check("rst_ssdSel",    32'(io.ssdSel),    32'd0);
    check("rst_stepPulse", 32'(io.stepPulse), 32'd0);
    check("rst_btnState",  32'(io.btnState),  32'd0);
    check("rst_stepCount", 32'(io.stepCount), 32'd0);

    // Switch synchroniser latency
    rst = 1'b0;
    io.stepBtnRaw = 1'b0;
    io.ssdSelRaw  = 4'hA;
    io.ledSelRaw  = 2'b10;
    @(negedge clk);
    check("sw_lat1_ssdSel", 32'(io.ssdSel), 32'h0);
    @(negedge clk);
    check("sw_lat2_ssdSel", 32'(io.ssdSel), 32'hA);
    check("sw_lat2_ledSel", 32'(io.ledSel), 32'h2);
    repeat (8) @(negedge clk);

    // Clean press held 20 cycles, then release
    q_pulse.delete();
    io.stepBtnRaw = 1'b1;
    t0 = cyc + 1;
    repeat (20) @(negedge clk);
    check("clean_btnState_hi", 32'(io.btnState), 32'd1);
    io.stepBtnRaw = 1'b0;
    t0 = cyc + 1;
    off = first_off(t0 - 20);
    repeat (6) @(negedge clk);
    check("clean_btnState_t5", 32'(io.btnState), 32'd1);
    @(negedge clk);
    check("clean_btnState_t6", 32'(io.btnState), 32'd0);
    repeat (3) @(negedge clk);
    check("clean_latency",   32'(off),            32'd6);
    check("clean_pulses",    32'(q_pulse.size()), 32'(CLEAN_PULSES));
    check("clean_stepCount", 32'(io.stepCount),   32'(CLEAN_PULSES));

    // Press bounce 1,0,1,0,1 then steady
    q_pulse.delete();
    io.stepBtnRaw = 1'b1; @(negedge clk);
    io.stepBtnRaw = 1'b0; @(negedge clk);
    io.stepBtnRaw = 1'b1; @(negedge clk);
    io.stepBtnRaw = 1'b0; @(negedge clk);
    io.stepBtnRaw = 1'b1;
    t0 = cyc + 1;
    repeat (13) @(negedge clk);
    check("bounce_pulses",    32'(q_pulse.size()), 32'd1);
    check("bounce_latency",   32'(first_off(t0)),  32'd6);
    check("bounce_stepCount", 32'(io.stepCount),   32'(CLEAN_PULSES + 1));

    // Release bounce 0,1,0 then steady
    q_pulse.delete();
    io.stepBtnRaw = 1'b0; @(negedge clk);
    io.stepBtnRaw = 1'b1; @(negedge clk);
    io.stepBtnRaw = 1'b0;
    t0 = cyc + 1;
    repeat (6) @(negedge clk);
    check("relb_btnState_t5", 32'(io.btnState), 32'd1);
    @(negedge clk);
    check("relb_btnState_t6", 32'(io.btnState), 32'd0);
    repeat (4) @(negedge clk);
    check("relb_pulses",    32'(q_pulse.size()), 32'd0);
    check("relb_stepCount", 32'(io.stepCount),   32'(CLEAN_PULSES + 1));

    // Counter wrap from 0xFFFF
    force dut.r_step_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_step_count;
    @(negedge clk);
    check("wrap_preload", 32'(io.stepCount), 32'hFFFF);
    q_pulse.delete();
    io.stepBtnRaw = 1'b1;
    repeat (12) @(negedge clk);
    io.stepBtnRaw = 1'b0;
    repeat (10) @(negedge clk);
    check("wrap_pulses",    32'(q_pulse.size()), 32'd1);
    check("wrap_stepCount", 32'(io.stepCount),   32'h0000);

    // Reset mid-PRESS_WAIT, button held through reset release
    q_pulse.delete();
    io.stepBtnRaw = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_state",     32'(dut.r_state),  32'(ST_IDLE));
    check("rstmid_stepCount", 32'(io.stepCount), 32'd0);
    repeat (3) @(negedge clk);
    check("rstmid_no_pulse", 32'(q_pulse.size()), 32'd0);
    rst = 1'b0;
    t0 = cyc + 1;
    repeat (10) @(negedge clk);
    check("rsthold_pulses",    32'(q_pulse.size()), 32'd1);
    check("rsthold_latency",   32'(first_off(t0)),  32'd6);
    check("rsthold_stepCount", 32'(io.stepCount),   32'd1);
    io.stepBtnRaw = 1'b0;
    repeat (10) @(negedge clk);

`ifdef AUTO_REPEAT_EN
    // Hold-to-repeat for 30 cycles
    begin
      int exp_off[7] = '{6, 16, 19, 22, 25, 28, 31};
      q_pulse.delete();
      io.stepBtnRaw = 1'b1;
      t0 = cyc + 1;
      repeat (30) @(negedge clk);
      io.stepBtnRaw = 1'b0;
      repeat (15) @(negedge clk);
      check("rep_pulses", 32'(q_pulse.size()), 32'd7);
      for (int i = 0; i < 7; i++) begin
        off = (i < q_pulse.size()) ? q_pulse[i] - t0 : -1;
        check($sformatf("rep_off%0d", i), 32'(off), 32'(exp_off[i]));
      end
      check("rep_stepCount", 32'(io.stepCount), 32'd8);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
